// File: rtl/instr_loader.sv
// Instruction loader: encodes RV32 LOAD/STORE/R/I fields and writes them into instruction memory.
// Latency: one cycle from accept to mem_we; at most one instruction every two cycles.
// Backpressure: in_ready is low while a write is pending, while full, and while clear is asserted.
// Optional feature: define ILLEGAL_CHECK_EN to flag and drop illegal ALU encodings via sticky err.
module instr_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_class,
    input  logic [3:0]        alu_fn,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [11:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_RALU  = 2'b10;
    localparam logic [1:0] OP_IALU  = 2'b11;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [ADDR_W:0]     count_q, count_nxt, count_inc;
    logic [31:0]         wdata_q, wdata_nxt;
    logic [31:0]         enc_word;
    logic [6:0]          funct7;
    logic                accept;
    logic                illegal;

    assign in_ready  = (state == IDLE) && !clear;
    assign accept    = in_valid && in_ready;
    assign mem_we    = (state == WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign count_inc = count_q + 1'b1;
    assign funct7    = {1'b0, alu_fn[3], 5'b00000};

    // Encode the presented fields into a 32-bit instruction word.
    always_comb begin
        enc_word = '0;
        case (op_class)
            OP_LOAD:  enc_word = {imm, rs1, 3'b010, rd, 7'b0000011};
            OP_STORE: enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            OP_RALU:  enc_word = {funct7, rs2, rs1, alu_fn[2:0], rd, 7'b0110011};
            OP_IALU: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (alu_fn[2:0] == 3'b001 || alu_fn[2:0] == 3'b101)
                    enc_word = {funct7, imm[4:0], rs1, alu_fn[2:0], rd, 7'b0010011};
                else
                    enc_word = {imm, rs1, alu_fn[2:0], rd, 7'b0010011};
            end
            default:  enc_word = '0;
        endcase
    end

`ifdef ILLEGAL_CHECK_EN
    logic err_q;

    // Only SUB/SRA (R) and SRAI (I) may use the alternate funct7 bit.
    always_comb begin
        illegal = 1'b0;
        if (op_class == OP_RALU && alu_fn[3] &&
            alu_fn[2:0] != 3'b000 && alu_fn[2:0] != 3'b101)
            illegal = 1'b1;
        if (op_class == OP_IALU && alu_fn[3] && alu_fn[2:0] != 3'b101)
            illegal = 1'b1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (accept && illegal)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

    // Next-state, address, count and write-data selection.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        count_nxt = count_q;
        wdata_nxt = wdata_q;
        case (state)
            IDLE: begin
                if (clear) begin
                    addr_nxt  = '0;
                    count_nxt = '0;
                end else if (accept && !illegal) begin
                    wdata_nxt = enc_word;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
                if (clear) begin
                    addr_nxt  = '0;
                    count_nxt = '0;
                end else begin
                    count_nxt = count_inc;
                    // Address stays on the last word once full so it never exceeds DEPTH-1.
                    if (count_inc == DEPTH_C)
                        state_nxt = FULL;
                    else
                        addr_nxt = addr_q + 1'b1;
                end
            end
            FULL: begin
                if (clear) begin
                    addr_nxt  = '0;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            count_q <= count_nxt;
            wdata_q <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader with DEPTH=4: directed literal cases, then randomized traffic
// checked every cycle against a word-level model of the loader.
module tb_instr_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset, clear, in_valid;
    logic              in_ready;
    logic [1:0]        op_class;
    logic [3:0]        alu_fn;
    logic [4:0]        rd, rs1, rs2;
    logic [11:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    bit          m_pend;
    int          m_cnt;
    bit          m_err;
    logic [31:0] m_word;

    always #5 clk = ~clk;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .alu_fn(alu_fn), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction word built from field values by arithmetic.
    function automatic logic [31:0] enc(input int unsigned cls, input int unsigned fn,
                                        input int unsigned rdv, input int unsigned r1,
                                        input int unsigned r2, input int unsigned im);
        int unsigned f3 = fn % 8;
        int unsigned f7 = (fn / 8 == 1) ? 32 : 0;
        int unsigned w;
        case (cls)
            0: w = (im << 20) + (r1 << 15) + (2 << 12) + (rdv << 7) + 3;
            1: w = ((im / 32) << 25) + (r2 << 20) + (r1 << 15) + (2 << 12) + ((im % 32) << 7) + 35;
            2: w = (f7 << 25) + (r2 << 20) + (r1 << 15) + (f3 << 12) + (rdv << 7) + 51;
            default: begin
                if (f3 == 1 || f3 == 5)
                    w = (f7 << 25) + ((im % 32) << 20);
                else
                    w = im << 20;
                w = w + (r1 << 15) + (f3 << 12) + (rdv << 7) + 19;
            end
        endcase
        return w;
    endfunction

    function automatic bit is_illegal(input int unsigned cls, input int unsigned fn);
`ifdef ILLEGAL_CHECK_EN
        if (cls == 2 && fn >= 8 && fn % 8 != 0 && fn % 8 != 5) return 1'b1;
        if (cls == 3 && fn >= 8 && fn % 8 != 5) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Model: a pending word is written the cycle after acceptance; the count saturates at DEPTH.
    initial begin
        m_pend = 1'b0; m_cnt = 0; m_err = 1'b0; m_word = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_pend = 1'b0; m_cnt = 0; m_err = 1'b0; m_word = '0;
            end else if (m_pend) begin
                m_pend = 1'b0;
                m_cnt  = clear ? 0 : m_cnt + 1;
            end else if (clear) begin
                m_cnt = 0;
            end else if (in_valid && m_cnt != DEPTH) begin
                if (is_illegal(op_class, alu_fn)) begin
                    m_err = 1'b1;
                end else begin
                    m_pend = 1'b1;
                    m_word = enc(op_class, alu_fn, rd, rs1, rs2, imm);
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("mdl_mem_we", mem_we, m_pend);
                check("mdl_count", count, m_cnt);
                check("mdl_full", full, m_cnt == DEPTH);
                check("mdl_err", err, m_err);
                check("mdl_in_ready", in_ready, !m_pend && m_cnt != DEPTH && !clear);
                check("mdl_wdata", mem_wdata, m_word);
                check("mdl_addr_range", mem_addr <= DEPTH - 1, 1);
                if (m_pend) check("mdl_mem_addr", mem_addr, m_cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_fields(input int cls, input int fn, input int rdv, input int r1,
                              input int r2, input int im);
        op_class = 2'(cls); alu_fn = 4'(fn); rd = 5'(rdv);
        rs1 = 5'(r1); rs2 = 5'(r2); imm = 12'(im);
    endtask

    task automatic issue(input int cls, input int fn, input int rdv, input int r1,
                         input int r2, input int im);
        set_fields(cls, fn, rdv, r1, r2, im);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_write(input string name, input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        check({name, "_we"}, mem_we, 1);
        check({name, "_addr"}, mem_addr, a);
        check({name, "_wdata"}, mem_wdata, w);
        step();
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0);
        repeat (2) step();
        reset = 1'b0;
        chk_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        step();

        // R-type add then count
        issue(2, 0, 3, 1, 2, 0);
        expect_write("r_add", 0, 32'h002081B3);
        @(negedge clk);
        check("r_add_count", count, 1);
        step();

        clear = 1'b1; step(); clear = 1'b0;
        @(negedge clk);
        check("clear_count", count, 0);
        step();

        // fill all four words with distinct classes
        issue(0, 0, 5, 2, 0, 8);
        expect_write("load", 0, 32'h00812283);
        issue(1, 0, 0, 2, 6, 12);
        expect_write("store", 1, 32'h00612623);
        issue(2, 8, 3, 1, 2, 0);
        expect_write("r_sub", 2, 32'h402081B3);
        issue(3, 0, 1, 0, 0, 12'hFFF);
        expect_write("i_addi", 3, 32'hFFF00093);
        @(negedge clk);
        check("full_flag", full, 1);
        check("full_in_ready", in_ready, 0);
        check("full_count", count, DEPTH);
        step();

        // valid held while full: nothing may be written
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("full_hold_we", mem_we, 0);
            step();
        end

        // clear with valid held: clear cycle not accepted, restart at address 0
        clear = 1'b1;
        @(negedge clk);
        check("clear_no_ready", in_ready, 0);
        step();
        clear = 1'b0;
        set_fields(3, 5, 7, 4, 0, 3);
        step();
        @(negedge clk);
        check("restart_we", mem_we, 1);
        check("restart_addr", mem_addr, 0);
        step();
        repeat (8) step();
        @(negedge clk);
        check("held_fill_count", count, DEPTH);
        check("held_fill_full", full, 1);
        step();
        in_valid = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;

        // R-type alu_fn=1001
        issue(2, 9, 3, 1, 2, 0);
`ifdef ILLEGAL_CHECK_EN
        @(negedge clk);
        check("illegal_we", mem_we, 0);
        check("illegal_err", err, 1);
        check("illegal_count", count, 0);
        step();
`else
        expect_write("r_fn1001", 0, 32'h402091B3);
`endif
        reset = 1'b1; step(); reset = 1'b0;

        // reset on the accept cycle
        set_fields(2, 0, 3, 1, 2, 0);
        in_valid = 1'b1; reset = 1'b1;
        step();
        in_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("rst_acc_we", mem_we, 0);
        check("rst_acc_count", count, 0);
        check("rst_acc_ready", in_ready, 1);
        step();

        // reset during the write cycle
        issue(0, 0, 1, 1, 0, 4);
        reset = 1'b1; step(); reset = 1'b0;
        @(negedge clk);
        check("rst_wr_we", mem_we, 0);
        check("rst_wr_count", count, 0);
        step();

        // randomized traffic
        repeat (3000) begin
            reset    = ($urandom_range(0, 199) == 0);
            clear    = ($urandom_range(0, 29) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            set_fields($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 4095));
            step();
        end
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: DEPTH, 64, number of instruction-memory words writable before full.
REQ-002 Parameter: ADDR_W, 6, word-address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: clear  input  1  synchronous restart of load address and count.
REQ-006 Port: in_valid  input  1  instruction fields valid.
REQ-007 Port: in_ready  output  1  loader accepts fields this cycle.
REQ-008 Port: op_class  input  2  00 LOAD, 01 STORE, 10 R-type ALU, 11 I-type ALU.
REQ-009 Port: alu_fn  input  4  {funct7[5], funct3} for ALU classes; ignored for LOAD/STORE.
REQ-010 Port: rd, rs1, rs2  input  5 each  register fields.
REQ-011 Port: imm  input  12  signed immediate.
REQ-012 Port: mem_we  output  1  instruction-memory write strobe.
REQ-013 Port: mem_addr  output  ADDR_W  word address.
REQ-014 Port: mem_wdata  output  32  encoded instruction word.
REQ-015 Port: count  output  ADDR_W+1  words written since reset/clear.
REQ-016 Port: full  output  1  count == DEPTH.
REQ-017 Port: err  output  1  sticky illegal-field flag.

Function
REQ-018 Encoding: LOAD = {imm, rs1, 010, rd, 0000011}; STORE = {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}; R = {0,alu_fn[3],00000, rs2, rs1, alu_fn[2:0], rd, 0110011}; I = {imm, rs1, alu_fn[2:0], rd, 0010011}, except alu_fn[2:0]=001/101 SHALL force word[31:25] = {0,alu_fn[3],00000}.
REQ-019 FSM states IDLE, WRITE, FULL; reset state IDLE.
REQ-020 in_ready SHALL be 1 only in IDLE with clear=0; accept = in_valid & in_ready.
REQ-021 IDLE -> WRITE on accept; encoded word registered into mem_wdata.
REQ-022 WRITE: mem_we=1 for exactly one cycle with mem_addr = current address; next cycle address and count increment by 1.
REQ-023 WRITE -> FULL if incremented count == DEPTH, else -> IDLE; throughput one instruction per 2 cycles, latency accept-to-mem_we one cycle.
REQ-024 FULL: in_ready=0, full=1, mem_we=0; exits to IDLE only on clear or reset.
REQ-025 clear in IDLE or FULL: address, count, full -> 0, state IDLE next cycle; clear with in_valid SHALL NOT accept.
REQ-026 clear during WRITE: the pending write completes, then address/count -> 0 instead of incrementing.
REQ-027 mem_addr SHALL never exceed DEPTH-1; no wrap-around while not full.
REQ-028 mem_wdata holds its last value when mem_we=0.

Reset
REQ-029 reset SHALL override clear and in_valid; next cycle: state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0, in_ready=1.
REQ-030 reset asserted in WRITE SHALL suppress mem_we in the following cycle; the aborted word is not counted.

Configuration
REQ-031 Macro ILLEGAL_CHECK_EN defined: illegal = (R-type with alu_fn[3]=1 and alu_fn[2:0] not 000/101) or (I-type with alu_fn[3]=1 and alu_fn[2:0] != 101); an illegal accept SHALL set err, return to IDLE next cycle without mem_we, and leave address/count unchanged.
REQ-032 Macro undefined: err tied 0; all accepted fields encoded and written per REQ-018.

Verification
REQ-033 Reset, then R-type rd=3 rs1=1 rs2=2 alu_fn=0000 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x002081B3, then count=1.
REQ-034 LOAD rd=5 rs1=2 imm=8, then STORE rs1=2 rs2=6 imm=12 -> writes 0x00812283 at addr 0, 0x00612623 at addr 1.
REQ-035 R-type alu_fn=1000 rd=3 rs1=1 rs2=2 -> 0x402081B3; I-type alu_fn=0000 rd=1 rs1=0 imm=0xFFF -> 0xFFF00093.
REQ-036 DEPTH=4, in_valid held 1 -> writes at addr 0..3, full=1, in_ready=0 afterwards; clear -> count=0, next write at addr 0.
REQ-037 With ILLEGAL_CHECK_EN: R-type alu_fn=1001 -> err=1, no mem_we, count unchanged; without macro same input writes 0x40...-encoded word.
REQ-038 reset asserted on the accept cycle -> no mem_we next cycle, count=0, in_ready=1.
